// File: rtl/bcd_digit_seq.sv
// Binary-to-BCD digit extractor driving a shared multi-cycle divider with divisor 10.
// Optional leading-zero blanking (blank code 4'hF) when BCD_BLANK_EN is defined.
module bcd_digit_seq #(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [WIDTH-1:0]      req_value,
   output logic                  digits_valid,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  ovf,
   output logic                  err,
   output logic                  div_start,
   output logic [WIDTH-1:0]      div_x,
   output logic [WIDTH-1:0]      div_y,
   input  logic                  div_busy,
   input  logic                  div_valid,
   input  logic                  div_dbz,
   input  logic [WIDTH-1:0]      div_q,
   input  logic [WIDTH-1:0]      div_r
);

   localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

   // Ones position always starts at 0; higher positions start blank or zero.
`ifdef BCD_BLANK_EN
   localparam logic [4*DIGITS-1:0] STAGE_CLR = {(4*DIGITS){1'b1}} << 4;
`else
   localparam logic [4*DIGITS-1:0] STAGE_CLR = '0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      work_q, work_d;
   logic [KW-1:0]         k_q, k_d;
   logic [4*DIGITS-1:0]   stage_q, stage_d;
   logic [4*DIGITS-1:0]   digits_q, digits_d;
   logic                  digits_valid_q, digits_valid_d;
   logic                  ovf_q, ovf_d;
   logic                  err_q, err_d;
   logic                  div_start_q, div_start_d;

   always_comb begin
      state_d        = state_q;
      work_d         = work_q;
      k_d            = k_q;
      stage_d        = stage_q;
      digits_d       = digits_q;
      digits_valid_d = 1'b0;
      ovf_d          = ovf_q;
      err_d          = err_q;
      div_start_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               work_d      = req_value;
               k_d         = '0;
               stage_d     = STAGE_CLR;
               ovf_d       = 1'b0;
               err_d       = 1'b0;
               div_start_d = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (div_valid && !div_busy) begin
               if (div_dbz) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  stage_d[4*int'(k_q) +: 4] = div_r[3:0];
                  work_d = div_q;
                  if (div_q == '0 || k_q == K_LAST) begin
                     // A nonzero quotient after the last digit means digits were dropped.
                     ovf_d   = (div_q != '0);
                     state_d = DONE;
                  end else begin
                     k_d         = k_q + 1'b1;
                     div_start_d = 1'b1;
                     state_d     = ISSUE;
                  end
               end
               if (state_d == DONE) begin
                  digits_d       = stage_d;
                  digits_valid_d = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         work_q         <= '0;
         k_q            <= '0;
         stage_q        <= '0;
         digits_q       <= '0;
         digits_valid_q <= 1'b0;
         ovf_q          <= 1'b0;
         err_q          <= 1'b0;
         div_start_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         work_q         <= work_d;
         k_q            <= k_d;
         stage_q        <= stage_d;
         digits_q       <= digits_d;
         digits_valid_q <= digits_valid_d;
         ovf_q          <= ovf_d;
         err_q          <= err_d;
         div_start_q    <= div_start_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign digits_valid = digits_valid_q;
   assign digits       = digits_q;
   assign ovf          = ovf_q;
   assign err          = err_q;
   assign div_start    = div_start_q;
   assign div_x        = work_q;
   assign div_y        = WIDTH'(10);

   // Remainder is always below 10, so only its low nibble carries information.
   generate
      if (WIDTH > 4) begin : g_rem_hi
         logic unused_rem_hi;
         assign unused_rem_hi = ^div_r[WIDTH-1:4];
      end
   endgenerate

endmodule

// File: tb/tb_bcd_digit_seq.sv
// Randomized self-checking bench for bcd_digit_seq with a behavioural divider and decimal reference model.
module tb_bcd_digit_seq;
   localparam int WIDTH = 10;
   localparam int PER   = WIDTH + 2;
`ifdef BCD_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic             req_valid [2];
   logic             req_ready [2];
   logic [WIDTH-1:0] req_value [2];
   logic             digits_valid [2];
   logic             ovf [2];
   logic             err [2];
   logic             div_start [2];
   logic [WIDTH-1:0] div_x [2];
   logic [WIDTH-1:0] div_y [2];
   logic             div_busy [2]  = '{1'b0, 1'b0};
   logic             div_valid [2] = '{1'b0, 1'b0};
   logic             div_dbz [2]   = '{1'b0, 1'b0};
   logic [WIDTH-1:0] div_q [2]     = '{'0, '0};
   logic [WIDTH-1:0] div_r [2]     = '{'0, '0};
   logic [15:0]      digits4;
   logic [7:0]       digits2;

   int               cnt [2] = '{0, 0};
   logic [WIDTH-1:0] opx [2] = '{'0, '0};
   bit               force_dbz [2] = '{1'b0, 1'b0};

   int n_checks = 0;
   int n_fail   = 0;

   bcd_digit_seq #(.WIDTH(WIDTH), .DIGITS(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_value(req_value[0]),
      .digits_valid(digits_valid[0]), .digits(digits4), .ovf(ovf[0]), .err(err[0]),
      .div_start(div_start[0]), .div_x(div_x[0]), .div_y(div_y[0]),
      .div_busy(div_busy[0]), .div_valid(div_valid[0]), .div_dbz(div_dbz[0]),
      .div_q(div_q[0]), .div_r(div_r[0])
   );

   bcd_digit_seq #(.WIDTH(WIDTH), .DIGITS(2)) u_dut2 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_value(req_value[1]),
      .digits_valid(digits_valid[1]), .digits(digits2), .ovf(ovf[1]), .err(err[1]),
      .div_start(div_start[1]), .div_x(div_x[1]), .div_y(div_y[1]),
      .div_busy(div_busy[1]), .div_valid(div_valid[1]), .div_dbz(div_dbz[1]),
      .div_q(div_q[1]), .div_r(div_r[1])
   );

   // Divider: busy for WIDTH cycles after the start edge, then valid held until the next start.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (div_start[g]) begin
            cnt[g]       <= WIDTH;
            opx[g]       <= div_x[g];
            div_busy[g]  <= 1'b1;
            div_valid[g] <= 1'b0;
         end else if (cnt[g] > 0) begin
            cnt[g] <= cnt[g] - 1;
            if (cnt[g] == 1) begin
               div_busy[g]  <= 1'b0;
               div_valid[g] <= 1'b1;
               div_dbz[g]   <= force_dbz[g] || (div_y[g] == '0);
               if (force_dbz[g] || div_y[g] == '0) begin
                  div_q[g] <= '1;
                  div_r[g] <= opx[g];
               end else begin
                  div_q[g] <= opx[g] / div_y[g];
                  div_r[g] <= opx[g] % div_y[g];
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] get_dig(input int i);
      return (i == 0) ? digits4 : {8'h00, digits2};
   endfunction

   function automatic logic [15:0] cleared(input int nd);
      logic [15:0] d;
      d = '0;
      if (BLANK)
         for (int p = 1; p < nd; p++) d[4*p +: 4] = 4'hF;
      return d;
   endfunction

   // Decimal reference: digit count, overflow, value mod 10^nd as packed BCD with optional blanking.
   function automatic void ref_conv(input int value, input int nd,
                                    output logic [15:0] dig, output bit ov, output int n);
      int tot, t, pw;
      tot = 1;
      t = value;
      while (t >= 10) begin
         t = t / 10;
         tot++;
      end
      ov  = (tot > nd);
      n   = ov ? nd : tot;
      dig = '0;
      pw  = 1;
      for (int p = 0; p < nd; p++) begin
         if (BLANK && !ov && p >= tot) dig[4*p +: 4] = 4'hF;
         else                          dig[4*p +: 4] = 4'((value / pw) % 10);
         pw = pw * 10;
      end
   endfunction

   task automatic run_conv(input int i, input int value, input bit dbz);
      logic [15:0] exp_dig;
      bit          exp_ov;
      int          n, nd, guard, cyc, starts, last, pw;
      bit          got;
      nd = (i == 0) ? 4 : 2;
      ref_conv(value, nd, exp_dig, exp_ov, n);
      if (dbz) begin
         exp_dig = cleared(nd);
         exp_ov  = 1'b0;
         n       = 1;
      end
      force_dbz[i] = dbz;
      guard = 0;
      while (!req_ready[i] && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("ready_before", req_ready[i], 1);
      @(negedge clk);
      req_value[i] = WIDTH'(value);
      req_valid[i] = 1'b1;
      @(posedge clk);
      #1;
      if (!dbz) req_valid[i] = 1'b0;
      cyc = 1; starts = 0; last = 0; got = 1'b0; pw = 1;
      while (!got && cyc < 200) begin
         if (div_start[i]) begin
            starts++;
            check("div_y", div_y[i], 10);
            check("div_x", div_x[i], value / pw);
            check("start_gap", cyc - last, (starts == 1) ? 1 : PER);
            last = cyc;
            pw   = pw * 10;
         end
         if (dbz) check("ready_busy", req_ready[i], 0);
         if (digits_valid[i]) got = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      req_valid[i] = 1'b0;
      check("done_seen", got, 1);
      check("latency", cyc, 1 + n * PER);
      check("digits", get_dig(i), exp_dig);
      check("ovf", ovf[i], exp_ov);
      check("err", err[i], dbz);
      check("starts", starts, n);
      @(posedge clk);
      #1;
      check("dv_pulse", digits_valid[i], 0);
      check("ready_after", req_ready[i], 1);
      check("digits_hold", get_dig(i), exp_dig);
      force_dbz[i] = 1'b0;
   endtask

   task automatic check_reset_state(input int i);
      check("rst_ready", req_ready[i], 1);
      check("rst_dv", digits_valid[i], 0);
      check("rst_digits", get_dig(i), 0);
      check("rst_ovf", ovf[i], 0);
      check("rst_err", err[i], 0);
      check("rst_start", div_start[i], 0);
   endtask

   initial begin
      int dv_count, sel, v, r;
      reset        = 1'b0;
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      req_value[0] = '0;   req_value[1] = '0;
      #1 reset = 1'b1;
      #1;
      check_reset_state(0);
      check_reset_state(1);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_conv(0, 0, 1'b0);
      run_conv(0, 1023, 1'b0);
      run_conv(0, 7, 1'b0);
      run_conv(1, 123, 1'b0);
      run_conv(1, 5, 1'b0);
      run_conv(1, 99, 1'b0);

      // Reset during the second division of 456.
      @(negedge clk);
      req_value[0] = WIDTH'(456);
      req_valid[0] = 1'b1;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      repeat (18) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_reset_state(0);
      @(negedge clk);
      reset = 1'b0;
      dv_count = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (digits_valid[0]) dv_count++;
      end
      check("no_dv_after_rst", dv_count, 0);
      run_conv(0, 89, 1'b0);

      run_conv(0, 456, 1'b1);
      run_conv(0, 305, 1'b0);

      for (int t = 0; t < 30; t++) begin
         sel = int'($urandom_range(0, 1));
         r   = int'($urandom_range(0, 3));
         if (r == 0)      v = int'($urandom_range(0, 9));
         else if (r == 1) v = int'($urandom_range(10, 99));
         else             v = int'($urandom_range(0, 1023));
         run_conv(sel, v, ($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no_finish expected finish");
      $fatal(1, "bench time limit");
   end
endmodule
